// File: rtl/dist_pkg.sv
// Shared constants, FSM state encoding and 7-segment codes for the
// distance measurement / display path.
package dist_pkg;

  localparam int DIST_BIN_W = 17;
  localparam int DIST_MAX   = 99999;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active high; shared with the scan driver.
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  function automatic logic [6:0] seg7_encode(input logic [3:0] dig);
    logic [6:0] seg;
    case (dig)
      4'd0:    seg = 7'b011_1111;
      4'd1:    seg = 7'b000_0110;
      4'd2:    seg = 7'b101_1011;
      4'd3:    seg = 7'b100_1111;
      4'd4:    seg = 7'b110_0110;
      4'd5:    seg = 7'b110_1101;
      4'd6:    seg = 7'b111_1101;
      4'd7:    seg = 7'b000_0111;
      4'd8:    seg = 7'b111_1111;
      4'd9:    seg = 7'b110_1111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/dist_bin2bcd_if.sv
// Request/result bundle between the distance arithmetic (master) and the
// binary-to-BCD converter (slave).
import dist_pkg::*;

interface dist_bin2bcd_if;
  logic                  Start;
  logic [DIST_BIN_W-1:0] Bin;
  logic                  Busy;
  logic                  Done;
  logic                  Over;
  logic [3:0]            Hundred;
  logic [3:0]            Ten;
  logic [3:0]            One;
  logic [3:0]            D_Ten;
  logic [3:0]            D_Hundred;

  modport master (
    output Start, Bin,
    input  Busy, Done, Over, Hundred, Ten, One, D_Ten, D_Hundred
  );

  modport slave (
    input  Start, Bin,
    output Busy, Done, Over, Hundred, Ten, One, D_Ten, D_Hundred
  );
endinterface

// File: rtl/bcd_add3.sv
// One BCD digit correction step of the shift-and-add-3 algorithm.
module bcd_add3 (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  // A digit of 5 or more would overflow past 9 after the next doubling.
  always_comb begin
    if (dig_i >= 4'd5) begin
      dig_o = dig_i + 4'd3;
    end else begin
      dig_o = dig_i;
    end
  end

endmodule

// File: rtl/dist_bin2bcd.sv
// Sequential binary-to-BCD converter for the echo distance; digits only
// change when a conversion completes so the display never sees partials.
module dist_bin2bcd
  import dist_pkg::*;
#(
  parameter int BIN_W   = DIST_BIN_W,
  parameter int MAX_VAL = DIST_MAX,
  parameter int N_DIG   = BCD_DIGITS
) (
  input  logic          CLK,
  input  logic          RSTn,
  dist_bin2bcd_if.slave bus
);

  localparam int ACC_W = 4 * N_DIG;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(MAX_VAL);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [BIN_W-1:0]   opr_q;
  logic               over_pend_q;
  logic [ACC_W-1:0]   dig_q;
  logic               over_q;
  logic               busy_q;
  logic               done_q;

  logic [ACC_W-1:0]   acc_adj_s;
  logic [ACC_W-1:0]   acc_d;
  logic [BIN_W-1:0]   opr_d;
  logic               bin_over_s;
  logic [BIN_W-1:0]   bin_clamp_s;

  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .dig_i (acc_q[4*gi +: 4]),
      .dig_o (acc_adj_s[4*gi +: 4])
    );
  end

  // Clamp the operand at acceptance and form the next shifted pair.
  always_comb begin
    bin_over_s     = (bus.Bin > MAX_BIN);
    bin_clamp_s    = bin_over_s ? MAX_BIN : bus.Bin;
    {acc_d, opr_d} = {acc_adj_s[ACC_W-2:0], opr_q, 1'b0};
  end

  // Conversion FSM with registered handshake and digit outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opr_q       <= '0;
      over_pend_q <= 1'b0;
      dig_q       <= '0;
      over_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            opr_q       <= bin_clamp_s;
            over_pend_q <= bin_over_s;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= SHIFT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          opr_q <= opr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= LOAD;
          end else begin
            state_q <= SHIFT;
          end
        end
        LOAD: begin
          dig_q   <= acc_q;
          over_q  <= over_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Over      = over_q;
  assign bus.Hundred   = dig_q[19:16];
  assign bus.Ten       = dig_q[15:12];
  assign bus.One       = dig_q[11:8];
  assign bus.D_Ten     = dig_q[7:4];
  assign bus.D_Hundred = dig_q[3:0];

endmodule

// File: tb/tb_dist_bin2bcd.sv
// Self-checking bench for dist_bin2bcd: vector table, scoreboard queue and
// hand-written sequences for ignored starts and mid-conversion reset.
module tb_dist_bin2bcd;
  import dist_pkg::*;

  typedef struct {
    logic [16:0] bin;
    logic [19:0] dig;
    logic        over;
  } vec_t;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  dist_bin2bcd_if bus ();

  dist_bin2bcd u_dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  vec_t        sb_q[$];
  vec_t        vecs[12];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] last_dig  = 20'h0;
  logic        last_over = 1'b0;

  function automatic logic [19:0] digs_now();
    return {bus.Hundred, bus.Ten, bus.One, bus.D_Ten, bus.D_Hundred};
  endfunction

  function automatic vec_t model(input logic [16:0] b);
    vec_t r;
    int   v;
    v      = (int'(b) > 99999) ? 99999 : int'(b);
    r.bin  = b;
    r.over = (int'(b) > 99999);
    r.dig  = {4'((v / 10000) % 10), 4'((v / 1000) % 10), 4'((v / 100) % 10),
              4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start a conversion now; optionally pulse a second Start at cycle ign_at.
  task automatic run_conv(input vec_t e, input int ign_at, input logic [16:0] ign_bin);
    vec_t g;
    int   lat;
    int   busy_n;
    bit   held;
    sb_q.push_back(e);
    bus.Start = 1'b1;
    bus.Bin   = e.bin;
    @(negedge CLK);
    bus.Start = 1'b0;
    bus.Bin   = 17'($urandom);
    lat = 0; busy_n = 0; held = 1'b1;
    while (!bus.Done && lat < 40) begin
      if (bus.Busy) busy_n++;
      if (digs_now() !== last_dig || bus.Over !== last_over) held = 1'b0;
      if (lat == ign_at) begin
        bus.Start = 1'b1;
        bus.Bin   = ign_bin;
      end
      @(negedge CLK);
      lat++;
      bus.Start = 1'b0;
    end
    chk("done_seen", {31'd0, bus.Done}, 32'd1);
    chk("latency", lat, 32'd18);
    chk("busy_cycles", busy_n, 32'd18);
    chk("hold_prev", {31'd0, held}, 32'd1);
    g = sb_q.pop_front();
    if (bus.Done) begin
      chk("digits", {12'd0, digs_now()}, {12'd0, g.dig});
      chk("over", {31'd0, bus.Over}, {31'd0, g.over});
      chk("busy_at_done", {31'd0, bus.Busy}, 32'd0);
      last_dig  = g.dig;
      last_over = g.over;
    end
  endtask

  initial begin
    vec_t e;
    vecs[0]  = '{17'd0,      20'h00000, 1'b0};
    vecs[1]  = '{17'd12345,  20'h12345, 1'b0};
    vecs[2]  = '{17'd99999,  20'h99999, 1'b0};
    vecs[3]  = '{17'd100000, 20'h99999, 1'b1};
    vecs[4]  = '{17'd131071, 20'h99999, 1'b1};
    vecs[5]  = '{17'd1,      20'h00001, 1'b0};
    vecs[6]  = '{17'd10,     20'h00010, 1'b0};
    vecs[7]  = '{17'd65536,  20'h65536, 1'b0};
    vecs[8]  = '{17'd50000,  20'h50000, 1'b0};
    vecs[9]  = '{17'd98765,  20'h98765, 1'b0};
    vecs[10] = '{17'd100,    20'h00100, 1'b0};
    vecs[11] = '{17'd9,      20'h00009, 1'b0};

    bus.Start = 1'b0;
    bus.Bin   = 17'd0;
    repeat (3) @(negedge CLK);
    chk("rst_digits", {12'd0, digs_now()}, 32'd0);
    chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst_done", {31'd0, bus.Done}, 32'd0);
    chk("rst_over", {31'd0, bus.Over}, 32'd0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Table runs back-to-back: each Start lands in the previous Done cycle.
    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i], -1, 17'd0);
    end
    for (int i = 0; i < 6; i++) begin
      run_conv(model(17'($urandom_range(0, 131071))), -1, 17'd0);
    end
    @(negedge CLK);
    chk("done_pulse_width", {31'd0, bus.Done}, 32'd0);

    // Start while busy is ignored and does not disturb the latched operand.
    run_conv(model(17'd12345), 5, 17'd678);
    repeat (3) @(negedge CLK);
    run_conv(model(17'd678), -1, 17'd0);
    chk("digits_678", {12'd0, digs_now()}, 32'h00678);
    repeat (2) @(negedge CLK);

    // Reset nine cycles into a conversion aborts it without a Done.
    e = model(17'd4321);
    sb_q.push_back(e);
    bus.Start = 1'b1;
    bus.Bin   = e.bin;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (9) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("midrst_digits", {12'd0, digs_now()}, 32'd0);
    chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    chk("midrst_over", {31'd0, bus.Over}, 32'd0);
    void'(sb_q.pop_back());
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("midrst_no_done", {31'd0, bus.Done}, 32'd0);
    end
    RSTn      = 1'b1;
    last_dig  = 20'h0;
    last_over = 1'b0;
    repeat (2) @(negedge CLK);
    chk("post_rst_idle", {31'd0, bus.Done | bus.Busy}, 32'd0);
    run_conv(model(17'd4321), -1, 17'd0);
    chk("digits_4321", {12'd0, digs_now()}, 32'h04321);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dist_bin2bcd.md
Name: dist_bin2bcd

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3) that turns the binary echo distance into five BCD digits for the 7-segment scan driver.
- Distance unit is 0.01 cm. Digit mapping: Hundred=10^4, Ten=10^3, One=10^2, D_Ten=10^1, D_Hundred=10^0. The display places its decimal point after One.
- Sits between the echo-timer/distance arithmetic and the display driver.
- Digit outputs change only on conversion completion, so the display never shows a partially converted value.

Parameters:
- BIN_W, 17, width of binary input.
- MAX_VAL, 99999, saturation ceiling; inputs above this are clamped.
- N_DIG, 5, number of BCD digits produced (fixed; not meant to be overridden).

Ports:
- CLK  input  1  system clock; the same clock as the display driver.
- RSTn  input  1  asynchronous active-low reset; assertion is asynchronous.
- Start  input  1  single-cycle request to convert Bin.
- Bin  input  BIN_W  binary distance in 0.01 cm units.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when new digits are valid.
- Over  output  1  registered with the digits; 1 = the last input exceeded MAX_VAL and was clamped.
- Hundred, Ten, One, D_Ten, D_Hundred  output  4 each  BCD digits, each always 0..9.

Behaviour:
- Reset (RSTn low, asynchronous): state IDLE, all digits 0, Busy 0, Done 0, Over 0, iteration counter 0, shift registers 0.
- States:
  - IDLE: Start=1 at an edge latches the operand and goes to SHIFT. Operand = min(Bin, MAX_VAL). Over_next = (Bin > MAX_VAL). BCD accumulator (20 bits) cleared. Counter cleared.
  - SHIFT: one iteration per edge.
    - First, each 4-bit accumulator digit >= 5 gets +3 (combinational).
    - Then {acc, operand} shifts left 1.
    - Counter increments. After BIN_W iterations, go to LOAD.
  - LOAD: digit outputs and Over take the accumulator/flag, Done=1 for this one cycle, then go to IDLE.
- Latency: Start sampled at edge k. Iterations occur at edges k+1..k+BIN_W. Outputs and Done update at edge k+BIN_W+1, i.e. edge k+18 at default.
- Throughput: back-to-back is allowed. A Start in the same cycle Done is high is accepted only from IDLE, so the minimum spacing between starts is BIN_W+2 cycles.
- Busy: 1 in SHIFT and LOAD, 0 in IDLE.
- Start while Busy: ignored; no queueing, and the latched operand is unchanged.
- Bin is sampled only at acceptance; later changes have no effect.
- Width rules:
  - Counter is $clog2(BIN_W+1) bits.
  - Accumulator is 4*N_DIG bits; with the clamp it never exceeds 99999.
  - Add-3 is applied before every shift, including the first; this is harmless because the accumulator is 0.
- Reset mid-conversion: aborts immediately. Outputs return to 0, no Done pulse.
- Outputs hold their last value indefinitely between conversions.

Decomposition:
- Shared package dist_pkg:
  - DIST_BIN_W=17, DIST_MAX=99999, BCD_DIGITS=5.
  - State enum {IDLE, SHIFT, LOAD}.
  - 7-segment digit codes, shared with the display driver.
- Sub-module bcd_add3: combinational 4-bit "if >=5 add 3", instantiated N_DIG times.

Test Plan:
- Bin=0, Start pulse -> Busy high for 18 cycles; at edge k+18 all digits 0, Over=0, Done pulses one cycle.
- Bin=12345 -> Hundred=1, Ten=2, One=3, D_Ten=4, D_Hundred=5, Over=0; digits stay at their previous values until the Done cycle.
- Bin=99999 -> all digits 9, Over=0.
- Bin=100000 and Bin=131071 -> digits clamped to 9,9,9,9,9 with Over=1.
- Bin=12345 accepted; at k+5, Bin=678 with Start pulse -> ignored; result is 12345. A fresh Start with Bin=678 after Done -> 0,0,6,7,8.
- Start with Bin=4321; RSTn low at k+9 for 2 cycles -> outputs 0 immediately, no Done. After release, Start with Bin=4321 -> 0,4,3,2,1 at latency 18.
